node_seq_ctrl: RTL and testbench
================================

# node_seq_ctrl

Time-multiplexed neuron sequencer for a layer. It evaluates N_NODE neurons of N_IN inputs each using one shared float_mult and one shared float_adder instead of a full multiplier/adder tree per node. For each neuron it fetches activation/weight pairs from external synchronous memories, accumulates the products, adds the bias, applies the step activation (sign-bit test) and emits one result per neuron. It sits between the layer's activation/weight storage and the next layer's input registers.

## Interface
- N_IN, 10, inputs per neuron
- N_NODE, 4, neurons evaluated per start
- AW, $clog2(N_IN), activation address width
- WW, $clog2(N_NODE*(N_IN+1)), weight/bias address width
- clk  in  1  clock; all state changes on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a layer evaluation; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last neuron's result
- rd_en  out  1  memory read strobe, registered
- a_addr  out  AW  activation index k, registered
- w_addr  out  WW  node*(N_IN+1)+k, registered; k=N_IN selects the bias
- a_data  in  32  IEEE-754 single activation, valid the cycle after rd_en
- w_data  in  32  IEEE-754 single weight/bias, valid the cycle after rd_en
- out_valid  out  1  one-cycle pulse per neuron result
- out_idx  out  $clog2(N_NODE)  neuron index of out_data
- out_data  out  32  32'd1 if final sum sign bit is 0, else 32'd0

## Operation
- States: IDLE, FETCH, MAC, BFETCH, BADD, OUT, DONE.
- IDLE: busy=0. start=1 sets node=0, k=0, acc=32'h0, then goes to FETCH.
- FETCH: rd_en=1, a_addr=k, w_addr=node*(N_IN+1)+k, then goes to MAC.
- MAC: acc <= float_adder(acc, float_mult(a_data, w_data)). If k==N_IN-1, go to BFETCH. Otherwise k++ and go to FETCH.
- BFETCH: rd_en=1, w_addr=node*(N_IN+1)+N_IN, a_addr=0, then goes to BADD.
- BADD: acc <= float_adder(acc, w_data). a_data is ignored. Then goes to OUT.
- OUT: out_valid=1, out_idx=node, out_data=(acc[31]==0)?32'd1:32'd0.
  - If node==N_NODE-1, go to DONE.
  - Otherwise node++, k=0, acc=32'h0, go to FETCH.
- DONE: done=1, busy=0 next cycle, go to IDLE.
- Sign rule:
  - An exact +0.0 sum gives 1.
  - -0.0 gives 0.
  - NaN/Inf are not special-cased; only the sign bit counts.
- Summation order: sequential in k (0..N_IN-1), then bias. Results may differ in the last ulp from tree-ordered summation; the bench compares against a sequential-order model.
- start while busy (any state other than IDLE) is ignored. It is not queued.
- rd_en is low in MAC, BADD, OUT, DONE and IDLE.

## Timing
- Reset values: all outputs are 0. State=IDLE, acc=0, node=0, k=0.
- rst=1 mid-operation:
  - Aborts on the next edge to IDLE with all outputs 0.
  - No done or out_valid is produced for the aborted run.
  - Memory data returning after reset is ignored.
- Start accepted at edge of cycle 0 → FETCH in cycle 1.
- Per-neuron period: 2*N_IN + 3 cycles (N_IN FETCH/MAC pairs, BFETCH/BADD, OUT).
- out_valid for node n is high in cycle (n+1)*(2*N_IN+3). With defaults: cycles 23, 46, 69, 92.
- done is high in cycle N_NODE*(2*N_IN+3)+1 (defaults: 93). busy is 0 and start is accepted again from cycle 94.
- out_data/out_idx hold their values until the next OUT or reset.
- Memory contract: fixed 1-cycle read latency, no stall input. float_mult/float_adder are combinational and fit within one cycle.

## Test plan
- All a=1.0 (3F800000), all w=1.0, bias=0 → four out_valid pulses at cycles 23/46/69/92, out_data=1 for idx 0..3, done at 93.
- Node 2 weights=-1.0 (BF800000), others +1.0, a=1.0, bias 0 → out_data per idx = 1,1,0,1.
- a=0 for all k; bias node0=BF000000 (-0.5), node1=3F000000 (+0.5), node2=00000000, node3=80000000 → 0,1,1,0.
- Address check: rd_en/w_addr sequence for node 1 is 11..20 then bias 21; a_addr is 0..9. rd_en is never high two consecutive cycles.
- start held high continuously → exactly one done per 94-cycle run. start pulses at cycles 5 and 50 are ignored, with no extra out_valid.
- rst asserted at cycle 40, released at 41, start at 45 → no out_valid between 41 and 45. New run produces correct results starting with idx 0 at cycle 45+23.

Source files
------------

// File: rtl/node_seq_ctrl.sv
// ============================================================================
// node_seq_ctrl : time-multiplexed neuron sequencer
// Evaluates N_NODE step-activated neurons with one shared FP multiplier/adder.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module node_seq_ctrl #(
  parameter int N_IN   = 10,
  parameter int N_NODE = 4,
  parameter int AW     = $clog2(N_IN),
  parameter int WW     = $clog2(N_NODE*(N_IN+1)),
  parameter int IW     = (N_NODE > 1) ? $clog2(N_NODE) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] a_addr,
  output logic [WW-1:0] w_addr,
  input  logic [31:0]   a_data,
  input  logic [31:0]   w_data,
  output logic          out_valid,
  output logic [IW-1:0] out_idx,
  output logic [31:0]   out_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_MAC, S_BFETCH, S_BADD, S_OUT, S_DONE
  } state_t;

  // m[26] is the hidden bit, m[2] guard, m[1:0] round/sticky; round-to-nearest-even.
  function automatic logic [31:0] fp_round(input logic s, input logic signed [9:0] e,
                                           input logic [26:0] m);
    logic [24:0]       r;
    logic signed [9:0] er;
    logic              inc;
    inc = m[2] & (m[1] | m[0] | m[3]);
    r   = {1'b0, m[26:3]} + {24'h0, inc};
    er  = e;
    if (r[24]) begin
      r  = r >> 1;
      er = er + 10'sd1;
    end
    if (er >= 10'sd255) return {s, 8'hff, 23'h0};
    if (er <= 10'sd0)   return {s, 31'h0};
    return {s, er[7:0], r[22:0]};
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic              s;
    logic [47:0]       p;
    logic signed [9:0] e;
    logic [26:0]       m;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'hff || b[30:23] == 8'hff) return {s, 8'hff, 23'h0};
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 31'h0};
    p = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
    e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (p[47]) begin
      e = e + 10'sd1;
      m = {p[47:22], |p[21:0]};
    end else begin
      m = {p[46:21], |p[20:0]};
    end
    return fp_round(s, e, m);
  endfunction

  // A zero operand passes the other through unchanged, so +0 + -0 keeps the -0.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]       x, y;
    logic [7:0]        d;
    logic [49:0]       ys;
    logic [26:0]       mx, my;
    logic [27:0]       sum;
    logic signed [9:0] e;
    if (a[30:23] == 8'h00) return b;
    if (b[30:23] == 8'h00) return a;
    if (a[30:23] == 8'hff) return a;
    if (b[30:23] == 8'hff) return b;
    if (a[30:0] >= b[30:0]) begin
      x = a; y = b;
    end else begin
      x = b; y = a;
    end
    d  = x[30:23] - y[30:23];
    ys = {1'b1, y[22:0], 26'h0} >> d;
    my = (d > 8'd26) ? 27'd1 : {ys[49:24], |ys[23:0]};
    mx = {1'b1, x[22:0], 3'b000};
    e  = $signed({2'b00, x[30:23]});
    if (x[31] == y[31]) begin
      sum = {1'b0, mx} + {1'b0, my};
      if (sum[27]) begin
        mx = {sum[27:2], sum[1] | sum[0]};
        e  = e + 10'sd1;
      end else begin
        mx = sum[26:0];
      end
    end else begin
      mx = mx - my;
      if (mx == 27'h0) return 32'h0;
      for (int i = 0; i < 26; i++) begin
        if (!mx[26]) begin
          mx = mx << 1;
          e  = e - 10'sd1;
        end
      end
    end
    return fp_round(x[31], e, mx);
  endfunction

  state_t        state_q, state_d;
  logic [IW-1:0] node_q, node_d;
  logic [AW-1:0] k_q, k_d;
  logic [31:0]   acc_q, acc_d;
  logic          busy_d, done_d, rd_en_d, out_valid_d;
  logic [AW-1:0] a_addr_d;
  logic [WW-1:0] w_addr_d, base_d;
  logic [IW-1:0] out_idx_d;
  logic [31:0]   out_data_d;

  always_comb begin
    state_d = state_q;
    node_d  = node_q;
    k_d     = k_q;
    acc_d   = acc_q;
    case (state_q)
      S_IDLE: if (start) begin
        node_d  = '0;
        k_d     = '0;
        acc_d   = 32'h0;
        state_d = S_FETCH;
      end
      S_FETCH:  state_d = S_MAC;
      S_MAC: begin
        acc_d = fp_add(acc_q, fp_mul(a_data, w_data));
        if (k_q == AW'(N_IN-1)) begin
          state_d = S_BFETCH;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_BFETCH: state_d = S_BADD;
      S_BADD: begin
        acc_d   = fp_add(acc_q, w_data);
        state_d = S_OUT;
      end
      S_OUT: if (node_q == IW'(N_NODE-1)) begin
        state_d = S_DONE;
      end else begin
        node_d  = node_q + 1'b1;
        k_d     = '0;
        acc_d   = 32'h0;
        state_d = S_FETCH;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    base_d      = WW'(node_d) * WW'(N_IN+1);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    rd_en_d     = (state_d == S_FETCH) || (state_d == S_BFETCH);
    out_valid_d = (state_d == S_OUT);
    a_addr_d    = a_addr;
    w_addr_d    = w_addr;
    out_idx_d   = out_idx;
    out_data_d  = out_data;
    if (state_d == S_FETCH) begin
      a_addr_d = k_d;
      w_addr_d = base_d + WW'(k_d);
    end else if (state_d == S_BFETCH) begin
      a_addr_d = '0;
      w_addr_d = base_d + WW'(N_IN);
    end
    if (state_d == S_OUT) begin
      out_idx_d  = node_d;
      out_data_d = acc_d[31] ? 32'd0 : 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      node_q    <= '0;
      k_q       <= '0;
      acc_q     <= 32'h0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      a_addr    <= '0;
      w_addr    <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= 32'h0;
    end else begin
      state_q   <= state_d;
      node_q    <= node_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      busy      <= busy_d;
      done      <= done_d;
      rd_en     <= rd_en_d;
      a_addr    <= a_addr_d;
      w_addr    <= w_addr_d;
      out_valid <= out_valid_d;
      out_idx   <= out_idx_d;
      out_data  <= out_data_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_node_seq_ctrl.sv
// Scoreboard bench for node_seq_ctrl: directed layer runs, expected results queued
// at start time and checked by an independent output monitor.
`default_nettype none

module tb_node_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, rd_en, out_valid;
  logic [3:0]  a_addr;
  logic [5:0]  w_addr;
  logic [31:0] a_data = 32'h0, w_data = 32'h0;
  logic [1:0]  out_idx;
  logic [31:0] out_data;

  node_seq_ctrl #(.N_IN(10), .N_NODE(4)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .a_addr(a_addr), .w_addr(w_addr),
    .a_data(a_data), .w_data(w_data),
    .out_valid(out_valid), .out_idx(out_idx), .out_data(out_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] a_mem [10];
  logic [31:0] w_mem [44];
  always @(posedge clk) if (rd_en) begin
    a_data <= a_mem[a_addr];
    w_data <= w_mem[w_addr];
  end

  typedef struct { logic [1:0] idx; logic [31:0] data; int cyc; } exp_t;
  typedef struct { logic [3:0] a; logic [5:0] w; } rd_t;
  exp_t exp_q[$];
  int   done_q[$];
  rd_t  log_q[$];
  bit   log_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  exp_t e;
  int   dc;
  logic prev_rd = 1'b0;

  always @(negedge clk) begin
    if (out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_valid_unexpected cyc=%0d got idx=%0d data=%h want no output", cyc, out_idx, out_data);
      end else begin
        e = exp_q.pop_front();
        if (out_idx !== e.idx || out_data !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL out_result got idx=%0d data=%h cyc=%0d want idx=%0d data=%h cyc=%0d",
                   out_idx, out_data, cyc, e.idx, e.data, e.cyc);
        end
      end
    end
    if (done) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected cyc=%0d got done=1 want 0", cyc);
      end else begin
        dc = done_q.pop_front();
        if (cyc != dc) begin
          errors++;
          $display("FAIL done_cycle got %0d want %0d", cyc, dc);
        end
      end
    end
    if (rd_en) begin
      checks++;
      if (prev_rd) begin
        errors++;
        $display("FAIL rd_en_back_to_back cyc=%0d got 1,1 want 0,1", cyc);
      end
      if (log_en) log_q.push_back('{a: a_addr, w: w_addr});
    end
    prev_rd = rd_en;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic start_run(output int c0);
    @(negedge clk);
    start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // bits[n] is the expected out_data of neuron n; nres limits how many results are expected.
  task automatic push_run(input int c0, input logic [3:0] bits, input int nres, input bit with_done);
    for (int n = 0; n < nres; n++)
      exp_q.push_back('{idx: 2'(n), data: {31'h0, bits[n]}, cyc: c0 + 23*(n+1)});
    if (with_done) done_q.push_back(c0 + 93);
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] w, input logic [31:0] w_node2,
                      input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2,
                      input logic [31:0] b3);
    for (int k = 0; k < 10; k++) a_mem[k] = a;
    for (int n = 0; n < 4; n++)
      for (int k = 0; k < 10; k++) w_mem[n*11+k] = (n == 2) ? w_node2 : w;
    w_mem[10] = b0; w_mem[21] = b1; w_mem[32] = b2; w_mem[43] = b3;
  endtask

  int c0, c1;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_done", {31'h0, done}, 32'h0);
    chk("reset_rd_en", {31'h0, rd_en}, 32'h0);
    chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
    chk("reset_out_data", out_data, 32'h0);
    chk("reset_addr", {22'h0, a_addr, w_addr}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // All ones: every neuron sums to +10.0
    load(32'h3F800000, 32'h3F800000, 32'h3F800000, 0, 0, 0, 0);
    log_en = 1'b1;
    start_run(c0);
    push_run(c0, 4'b1111, 4, 1'b1);
    wait_cyc(c0 + 1);  chk("busy_first", {31'h0, busy}, 32'h1);
    wait_cyc(c0 + 93); chk("busy_at_done", {31'h0, busy}, 32'h1);
    wait_cyc(c0 + 94); chk("busy_after_done", {31'h0, busy}, 32'h0);
    log_en = 1'b0;
    chk("read_count", log_q.size(), 32'd44);
    if (log_q.size() == 44)
      for (int j = 0; j <= 10; j++) begin
        chk("node1_w_addr", {26'h0, log_q[11+j].w}, 32'(11 + j));
        chk("node1_a_addr", {28'h0, log_q[11+j].a}, (j < 10) ? 32'(j) : 32'h0);
      end
    out_hold_check: chk("out_hold", {30'h0, out_idx}, 32'd3);

    // Node 2 negative weights
    load(32'h3F800000, 32'h3F800000, 32'hBF800000, 0, 0, 0, 0);
    start_run(c0);
    push_run(c0, 4'b1011, 4, 1'b1);
    wait_cyc(c0 + 95);

    // Zero activations: bias alone decides, including signed zeros
    load(32'h00000000, 32'h3F800000, 32'h3F800000,
         32'hBF000000, 32'h3F000000, 32'h00000000, 32'h80000000);
    start_run(c0);
    push_run(c0, 4'b0110, 4, 1'b1);
    wait_cyc(c0 + 95);

    // start held high: back-to-back runs, one done each
    load(32'h3F800000, 32'h3F800000, 32'hBF800000, 0, 0, 0, 0);
    @(negedge clk);
    start = 1'b1;
    c0 = cyc;
    push_run(c0, 4'b1011, 4, 1'b1);
    push_run(c0 + 94, 4'b1011, 4, 1'b1);
    wait_cyc(c0 + 95);
    start = 1'b0;
    wait_cyc(c0 + 94 + 95);

    // start pulses while busy are ignored
    start_run(c0);
    push_run(c0, 4'b1011, 4, 1'b1);
    wait_cyc(c0 + 5);  start = 1'b1; @(negedge clk); start = 1'b0;
    wait_cyc(c0 + 50); start = 1'b1; @(negedge clk); start = 1'b0;
    wait_cyc(c0 + 100);
    chk("idle_after_pulses", {31'h0, busy}, 32'h0);

    // Mid-run reset, then a fresh run
    load(32'h3F800000, 32'h3F800000, 32'h3F800000, 0, 0, 0, 0);
    start_run(c0);
    push_run(c0, 4'b1111, 1, 1'b0);
    wait_cyc(c0 + 40); rst = 1'b1;
    wait_cyc(c0 + 41); rst = 1'b0;
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_rd_en", {31'h0, rd_en}, 32'h0);
    chk("abort_out_data", out_data, 32'h0);
    chk("abort_pending", exp_q.size(), 32'd0);
    wait_cyc(c0 + 44);
    start_run(c1);
    chk("restart_cycle", c1 - c0, 32'd45);
    push_run(c1, 4'b1111, 4, 1'b1);
    wait_cyc(c1 + 95);

    chk("leftover_results", exp_q.size(), 32'd0);
    chk("leftover_done", done_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
